// File: rtl/calc1_port_scheduler.sv
// Four-port request scheduler sharing one arithmetic/shift unit.
// Each port collects a two-cycle request, is granted round-robin into a one-deep issue register, and routes tagged results back.
module calc1_port_scheduler #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        c_clk,
    input  logic [1:7]  reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:31] req4_data_in,
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    output logic        alu_valid,
    input  logic        alu_ready,
    output logic [0:3]  alu_cmd,
    output logic [0:31] alu_op1,
    output logic [0:31] alu_op2,
    output logic [0:1]  alu_tag,
    input  logic        alu_done,
    input  logic [0:1]  alu_done_tag,
    input  logic [0:31] alu_result,
    input  logic [0:1]  alu_resp,
    output logic [1:4]  port_busy
);

    localparam int unsigned NPORT  = 4;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned TAG_W  = 2;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [RESP_W-1:0] RSP_ERR = RESP_W'(2);
    localparam logic [RESP_W-1:0] RSP_TMO = RESP_W'(3);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP2,
        ST_PEND,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t              state  [NPORT];
    logic [CMD_W-1:0]    cmd_q  [NPORT];
    logic [DATA_W-1:0]   op1_q  [NPORT];
    logic [DATA_W-1:0]   op2_q  [NPORT];
    logic [CNT_W-1:0]    cnt_q  [NPORT];
    logic [DATA_W-1:0]   data_q [NPORT];
    logic [RESP_W-1:0]   resp_q [NPORT];
    logic [NPORT-1:0]    busy_q;

    logic [CMD_W-1:0]    cmd_in  [NPORT];
    logic [DATA_W-1:0]   data_in [NPORT];

    logic                srst;
    logic                load;
    logic [TAG_W-1:0]    rr_last;
    logic                gnt_found;
    logic [TAG_W-1:0]    gnt_idx;
    logic [TAG_W-1:0]    cand;

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    assign out_data1 = data_q[0];
    assign out_data2 = data_q[1];
    assign out_data3 = data_q[2];
    assign out_data4 = data_q[3];
    assign out_resp1 = resp_q[0];
    assign out_resp2 = resp_q[1];
    assign out_resp3 = resp_q[2];
    assign out_resp4 = resp_q[3];
    assign port_busy = {busy_q[0], busy_q[1], busy_q[2], busy_q[3]};

    // Any asserted reset bit resets the block.
    assign srst = |reset;
    // The issue register may take a new request when empty or being accepted this edge.
    assign load = !alu_valid || alu_ready;

    function automatic logic valid_cmd(input logic [CMD_W-1:0] c);
        return (c == CMD_W'(1)) || (c == CMD_W'(2)) || (c == CMD_W'(5)) || (c == CMD_W'(6));
    endfunction

    // Round-robin search starting at the port after the last grant.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NPORT; k++) begin
            cand = rr_last + TAG_W'(k);
            if (!gnt_found && state[cand] == ST_PEND) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (srst) begin
            for (int p = 0; p < NPORT; p++) begin
                state[p]  <= ST_IDLE;
                cmd_q[p]  <= '0;
                op1_q[p]  <= '0;
                op2_q[p]  <= '0;
                cnt_q[p]  <= '0;
                data_q[p] <= '0;
                resp_q[p] <= '0;
            end
            busy_q    <= '0;
            alu_valid <= 1'b0;
            alu_cmd   <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_tag   <= '0;
            rr_last   <= TAG_W'(NPORT - 1);
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                data_q[p] <= '0;
                resp_q[p] <= '0;
                case (state[p])
                    ST_IDLE: begin
                        if (cmd_in[p] != '0) begin
                            cmd_q[p]  <= cmd_in[p];
                            op1_q[p]  <= data_in[p];
                            busy_q[p] <= 1'b1;
                            state[p]  <= ST_OP2;
                        end
                    end
                    ST_OP2: begin
                        op2_q[p] <= data_in[p];
                        if (valid_cmd(cmd_q[p])) begin
                            state[p] <= ST_PEND;
                        end else begin
                            resp_q[p] <= RSP_ERR;
                            state[p]  <= ST_RESP;
                        end
                    end
                    ST_PEND: begin
                        if (load && gnt_found && gnt_idx == TAG_W'(p)) begin
                            cnt_q[p] <= '0;
                            state[p] <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        // A result arriving on the timeout cycle wins over the timeout.
                        if (alu_done && alu_done_tag == TAG_W'(p)) begin
                            data_q[p] <= alu_result;
                            resp_q[p] <= alu_resp;
                            state[p]  <= ST_RESP;
                        end else if (cnt_q[p] == CNT_W'(TIMEOUT_CYC - 1)) begin
                            resp_q[p] <= RSP_TMO;
                            state[p]  <= ST_RESP;
                        end else begin
                            cnt_q[p] <= cnt_q[p] + CNT_W'(1);
                        end
                    end
                    ST_RESP: begin
                        busy_q[p] <= 1'b0;
                        state[p]  <= ST_IDLE;
                    end
                    default: state[p] <= ST_IDLE;
                endcase
            end

            if (load) begin
                alu_valid <= gnt_found;
                if (gnt_found) begin
                    alu_cmd <= cmd_q[gnt_idx];
                    alu_op1 <= op1_q[gnt_idx];
                    alu_op2 <= op2_q[gnt_idx];
                    alu_tag <= gnt_idx;
                    rr_last <= gnt_idx;
                end
            end
        end
    end

endmodule

// File: doc/calc1_port_scheduler.md
CALC1_PORT_SCHEDULER -- requirements
Module: calc1_port_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15, maximum cycles a port waits in BUSY for a shared-unit result.
REQ-002 SHALL have port c_clk  in  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  [1:7]  synchronous, active-high; asserting any bit resets the block.
REQ-004 SHALL have ports reqN_cmd_in  in  [0:3]  (N=1..4) command per requester: 0 none, 1 add, 2 sub, 5 shift-left, 6 shift-right.
REQ-005 SHALL have ports reqN_data_in  in  [0:31]  (N=1..4) operand 1 in the command cycle, operand 2 in the following cycle.
REQ-006 SHALL have ports out_dataN  out  [0:31]  (N=1..4) result returned to requester N.
REQ-007 SHALL have ports out_respN  out  [0:1]  (N=1..4) 0 none, 1 success, 2 overflow/underflow/invalid, 3 timeout.
REQ-008 SHALL have ports alu_valid out 1, alu_ready in 1, alu_cmd out [0:3], alu_op1 out [0:31], alu_op2 out [0:31], alu_tag out [0:1]: issue channel to the shared arithmetic/shift unit.
REQ-009 SHALL have ports alu_done in 1, alu_done_tag in [0:1], alu_result in [0:31], alu_resp in [0:1]: result return channel from the shared unit.
REQ-010 SHALL have port port_busy  out  [1:4]  bit N high while port N is not IDLE.

Function
REQ-011 Each port SHALL run FSM IDLE -> OP2 -> PEND -> BUSY -> RESP -> IDLE, one state per cycle except PEND/BUSY.
REQ-012 IDLE: nonzero reqN_cmd_in captures cmd and operand 1 -> OP2; zero cmd stays IDLE.
REQ-013 OP2: captures reqN_data_in as operand 2; valid cmd (1,2,5,6) -> PEND; any other cmd -> RESP with resp 2, data 0, never issued.
REQ-014 Commands presented while a port is not IDLE SHALL be ignored and produce no response.
REQ-015 Issue register SHALL hold one request; alu_valid high while loaded; payload stable until the edge where alu_valid and alu_ready are both high.
REQ-016 Arbiter SHALL load the issue register from PEND ports when it is empty or being accepted that same edge; selected port -> BUSY; alu_tag = port number minus 1.
REQ-017 Arbitration SHALL be round-robin: search starts at the port after the last granted; after reset, search starts at port 1.
REQ-018 Earliest timing: cmd in cycle T, operand 2 in T+1, alu_valid high in T+3.
REQ-019 alu_done with alu_done_tag matching a BUSY port SHALL move that port to RESP with alu_result and alu_resp; done for a non-BUSY tag SHALL be ignored.
REQ-020 RESP: out_dataN/out_respN SHALL show the result for exactly one cycle, then return to 0/0.
REQ-021 BUSY counter SHALL count cycles; reaching TIMEOUT_CYC without done -> RESP with resp 3, data 0.
REQ-022 alu_done and timeout in the same cycle: alu_done SHALL take priority.
REQ-023 Multiple ports may be BUSY at once; returns may arrive in any order and are routed by tag.
REQ-024 Operands and results SHALL pass unmodified; the block performs no arithmetic.

Reset
REQ-025 On reset all ports SHALL go to IDLE, issue register clear, round-robin pointer to port 1, BUSY counters 0.
REQ-026 During and after reset, until the next response, all out_dataN = 0, out_respN = 0, alu_valid = 0, port_busy = 0.
REQ-027 Reset asserted mid-operation SHALL discard every in-flight request with no response; later alu_done is ignored.

Verification
REQ-028 Port1 cmd 1, operands 1 and 0x1FFF_FFFF, unit returns 0x2000_0000 resp 1 -> out_data1 = 0x2000_0000, out_resp1 = 1 for one cycle.
REQ-029 Port1 cmd 3, operand 1 -> alu_valid stays 0; out_resp1 = 2, out_data1 = 0 at T+2.
REQ-030 All four ports issue cmd 5 in the same cycle, alu_ready held 1 -> grant order 1,2,3,4 with tags 0,1,2,3 on consecutive cycles.
REQ-031 Port2 issued, alu_done never asserted -> out_resp2 = 3, out_data2 = 0 after TIMEOUT_CYC BUSY cycles.
REQ-032 Reset asserted while port3 is BUSY, then alu_done tag 2 -> no output on out_resp3; port_busy = 0.
REQ-033 alu_ready held 0 for 5 cycles with port4 PEND -> alu_cmd/alu_op1/alu_op2/alu_tag remain constant until acceptance.
